// File: rtl/bt656_pkg.sv
// Shared constants for the BT.656 timing-reference decoder: preamble words,
// header (XY) bit positions, detector state encoding and the protection-bit rule.
package bt656_pkg;

   localparam int HDR_BIT_1 = 7;
   localparam int FIELD     = 6;
   localparam int VBLANK    = 5;
   localparam int HBLANK    = 4;
   localparam int P3        = 3;
   localparam int P2        = 2;
   localparam int P1        = 1;
   localparam int P0        = 0;

   localparam logic [7:0] PRE_FF = 8'hFF;
   localparam logic [7:0] PRE_00 = 8'h00;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      GOT_FF  = 2'd1,
      GOT_00A = 2'd2,
      GOT_00B = 2'd3
   } hdr_state_e;

   // Protection bits are the Hamming-style parity of F, V and H.
   function automatic logic prot_ok(input logic [7:0] xy);
      logic f, v, h;
      f = xy[FIELD];
      v = xy[VBLANK];
      h = xy[HBLANK];
      return (xy[P3] == (v ^ h)) && (xy[P2] == (f ^ h)) &&
             (xy[P1] == (f ^ v)) && (xy[P0] == (f ^ v ^ h));
   endfunction

endpackage

// File: rtl/bt656_if.sv
// Word-stream and decoded-timing bundle between a BT.656 source and the decoder.
// master = video source / consumer side, slave = decoder side.
interface bt656_if #(
   parameter int DW      = 10,
   parameter int PIX_CW  = 12,
   parameter int LINE_CW = 11
);
   logic [DW-1:0]      data_i;
   logic [DW-1:0]      data_o;
   logic               href_o;
   logic               vsync_o;
   logic               field_o;
   logic               sof_o;
   logic [PIX_CW-1:0]  pix_cnt_o;
   logic [LINE_CW-1:0] line_cnt_o;
   logic               lock_o;
   logic               hdr_err_o;

   modport master (
      output data_i,
      input  data_o, href_o, vsync_o, field_o, sof_o,
             pix_cnt_o, line_cnt_o, lock_o, hdr_err_o
   );

   modport slave (
      input  data_i,
      output data_o, href_o, vsync_o, field_o, sof_o,
             pix_cnt_o, line_cnt_o, lock_o, hdr_err_o
   );
endinterface

// File: rtl/bt656_hdr_detect.sv
// Preamble (FF 00 00) tracker and XY header classifier; flags are combinational
// in the XY cycle. Build option: BT656_PROT_CHECK_EN also checks protection bits.
//
// state   | meaning
// SEARCH  | no preamble prefix seen
// GOT_FF  | previous word was 0xFF
// GOT_00A | previous words were FF 00
// GOT_00B | previous words were FF 00 00, current word is XY
module bt656_hdr_detect
   import bt656_pkg::*;
(
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic [7:0] word_i,
   output logic       hdr_acc_o,
   output logic       hdr_rej_o,
   output logic       f_o,
   output logic       v_o,
   output logic       h_o
);

   hdr_state_e state, state_nxt;
   logic       is_xy;
   logic       xy_ok;

   // A 0xFF always restarts the preamble, even where an XY word is expected.
   always_comb begin
      state_nxt = SEARCH;
      if (word_i == PRE_FF) begin
         state_nxt = GOT_FF;
      end else begin
         case (state)
            GOT_FF:  if (word_i == PRE_00) state_nxt = GOT_00A;
            GOT_00A: if (word_i == PRE_00) state_nxt = GOT_00B;
            default: state_nxt = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state <= SEARCH;
      else         state <= state_nxt;
   end

   assign is_xy = (state == GOT_00B) && (word_i != PRE_FF);

`ifdef BT656_PROT_CHECK_EN
   assign xy_ok = word_i[HDR_BIT_1] && prot_ok(word_i);
`else
   logic unused_prot;
   assign unused_prot = ^word_i[P3:P0];
   assign xy_ok       = word_i[HDR_BIT_1];
`endif

   assign hdr_acc_o = is_xy && xy_ok;
   assign hdr_rej_o = is_xy && !xy_ok;
   assign f_o       = word_i[FIELD];
   assign v_o       = word_i[VBLANK];
   assign h_o       = word_i[HBLANK];

endmodule

// File: rtl/bt656_sync_decoder.sv
// BT.656 sync decoder: 4-stage tagged data pipeline, pixel/line counters, lock.
// Build option: BT656_PROT_CHECK_EN (header protection check, in bt656_hdr_detect).
module bt656_sync_decoder
   import bt656_pkg::*;
#(
   parameter int DW      = 10,
   parameter int PIX_CW  = 12,
   parameter int LINE_CW = 11,
   parameter int TIMEOUT = 4096
) (
   input  logic   clk_i,
   input  logic   rstn_i,
   bt656_if.slave bus
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic               hdr_acc, hdr_rej, hdr_f, hdr_v, hdr_h;
   logic               eav_acc;
   logic               active;
   logic [DW-1:0]      pipe_d [4];
   logic [3:0]         pipe_t;
   logic               tag4_nxt;
   logic               vsync_q, field_q, sof_q, err_q;
   logic               lock_q, seen_q;
   logic [PIX_CW-1:0]  pix_q;
   logic [LINE_CW-1:0] line_q;
   logic [TW-1:0]      tmo_q;

   bt656_hdr_detect u_hdr (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .word_i    (bus.data_i[DW-1 -: 8]),
      .hdr_acc_o (hdr_acc),
      .hdr_rej_o (hdr_rej),
      .f_o       (hdr_f),
      .v_o       (hdr_v),
      .h_o       (hdr_h)
   );

   assign eav_acc  = hdr_acc & hdr_h;
   assign tag4_nxt = pipe_t[2] & ~eav_acc;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         active <= 1'b0;
      end else if (hdr_acc) begin
         if (hdr_h)       active <= 1'b0;
         else if (!hdr_v) active <= 1'b1;
      end
   end

   // The EAV preamble was tagged active on entry; untag it once the EAV is known.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < 4; i++) pipe_d[i] <= '0;
         pipe_t <= '0;
      end else begin
         pipe_d[0] <= bus.data_i;
         for (int i = 1; i < 4; i++) pipe_d[i] <= pipe_d[i-1];
         pipe_t[0] <= active & ~hdr_acc;
         pipe_t[1] <= pipe_t[0] & ~eav_acc;
         pipe_t[2] <= pipe_t[1] & ~eav_acc;
         pipe_t[3] <= tag4_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pix_q <= '0;
      end else if (tag4_nxt) begin
         if (!pipe_t[3])       pix_q <= '0;
         else if (pix_q != '1) pix_q <= pix_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         vsync_q <= 1'b0;
         field_q <= 1'b0;
         sof_q   <= 1'b0;
         err_q   <= 1'b0;
         line_q  <= '0;
      end else begin
         err_q <= hdr_rej;
         sof_q <= 1'b0;
         if (hdr_acc) begin
            vsync_q <= hdr_v;
            field_q <= hdr_f;
            if ((vsync_q && !hdr_v) || (field_q != hdr_f)) begin
               sof_q  <= 1'b1;
               line_q <= '0;
            end else if (hdr_h && active && (line_q != '1)) begin
               line_q <= line_q + 1'b1;
            end
         end
      end
   end

   // Lock needs two accepted headers back to back; the timer is re-armed by each one.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         lock_q <= 1'b0;
         seen_q <= 1'b0;
         tmo_q  <= '0;
      end else if (hdr_acc) begin
         tmo_q  <= TW'(TIMEOUT);
         seen_q <= 1'b1;
         if (seen_q) lock_q <= 1'b1;
      end else if (hdr_rej) begin
         seen_q <= 1'b0;
         lock_q <= 1'b0;
      end else if (tmo_q != '0) begin
         tmo_q <= tmo_q - 1'b1;
         if (tmo_q == TW'(1)) begin
            seen_q <= 1'b0;
            lock_q <= 1'b0;
         end
      end
   end

   assign bus.data_o     = pipe_d[3];
   assign bus.href_o     = pipe_t[3];
   assign bus.vsync_o    = vsync_q;
   assign bus.field_o    = field_q;
   assign bus.sof_o      = sof_q;
   assign bus.pix_cnt_o  = pix_q;
   assign bus.line_cnt_o = line_q;
   assign bus.lock_o     = lock_q;
   assign bus.hdr_err_o  = err_q;

endmodule

// File: tb/tb_bt656_sync_decoder.sv
// Scoreboard bench for bt656_sync_decoder; the reference model works on word
// history (last three bytes, per-word tags) rather than on a detector state machine.
`timescale 1ns/1ps
module tb_bt656_sync_decoder;

   localparam int DW      = 10;
   localparam int PIX_CW  = 12;
   localparam int LINE_CW = 11;
   localparam int TIMEOUT = 4096;
`ifdef BT656_PROT_CHECK_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   bt656_if #(.DW(DW), .PIX_CW(PIX_CW), .LINE_CW(LINE_CW)) bus ();

   bt656_sync_decoder #(
      .DW(DW), .PIX_CW(PIX_CW), .LINE_CW(LINE_CW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   typedef struct packed {
      logic [DW-1:0]      data;
      logic               href;
      logic               vsync;
      logic               field;
      logic               sof;
      logic [PIX_CW-1:0]  pix;
      logic [LINE_CW-1:0] line;
      logic               lock;
      logic               err;
   } rec_t;

   rec_t exp_q[$];
   int   vectors = 0;
   int   errors  = 0;
   int   href_seen = 0;
   int   sof_seen  = 0;

   // reference model state
   logic [7:0]         h1, h2, h3;
   logic [DW:0]        pq[$];
   logic               m_active, m_v, m_f, m_lock, m_acc_valid, m_href_prev;
   logic [PIX_CW-1:0]  m_pix;
   logic [LINE_CW-1:0] m_line;
   int                 m_k, m_last_k;

   function automatic logic [7:0] mk_xy(input logic f, input logic v, input logic h);
      return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
   endfunction

   task automatic chk(input string name, input int got, input int expv);
      vectors++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, expv);
      end
   endtask

   task automatic model_reset();
      rec_t r;
      h1 = 8'h00; h2 = 8'h00; h3 = 8'h00;
      pq.delete();
      for (int i = 0; i < 3; i++) pq.push_back('0);
      m_active = 0; m_v = 0; m_f = 0; m_lock = 0; m_acc_valid = 0; m_href_prev = 0;
      m_pix = '0; m_line = '0; m_k = 0; m_last_k = 0;
      r = '0;
      exp_q.push_back(r);
   endtask

   task automatic model_step(input logic [DW-1:0] w);
      logic [7:0]  b, good;
      logic        is_hdr, acc, rej, f, v, h, sof;
      logic [DW:0] o;
      rec_t        r;
      b      = w[DW-1 -: 8];
      f      = b[6];
      v      = b[5];
      h      = b[4];
      good   = mk_xy(f, v, h);
      is_hdr = (h3 == 8'hFF) && (h2 == 8'h00) && (h1 == 8'h00) && (b != 8'hFF);
      acc    = is_hdr && b[7];
      if (PROT) acc = acc && (b[3:0] == good[3:0]);
      rej    = is_hdr && !acc;
      pq.push_back({m_active && !acc, w});
      if (acc && h) for (int i = 0; i < 3; i++) pq[i][DW] = 1'b0;
      o   = pq.pop_front();
      sof = 1'b0;
      if (acc) begin
         sof = (m_v && !v) || (m_f != f);
         if (sof) m_line = '0;
         else if (h && m_active && (m_line != '1)) m_line = m_line + 1'b1;
         m_v = v;
         m_f = f;
         if (m_acc_valid && (m_k - m_last_k) <= TIMEOUT) m_lock = 1'b1;
         m_acc_valid = 1'b1;
         m_last_k    = m_k;
         if (h) m_active = 1'b0;
         else if (!v) m_active = 1'b1;
      end else if (rej) begin
         m_lock = 1'b0;
         m_acc_valid = 1'b0;
      end else if (m_acc_valid && (m_k - m_last_k) >= TIMEOUT) begin
         m_lock = 1'b0;
         m_acc_valid = 1'b0;
      end
      if (o[DW]) begin
         if (!m_href_prev) m_pix = '0;
         else if (m_pix != '1) m_pix = m_pix + 1'b1;
      end
      m_href_prev = o[DW];
      h3 = h2; h2 = h1; h1 = b;
      m_k++;
      r.data = o[DW-1:0]; r.href = o[DW]; r.vsync = m_v; r.field = m_f; r.sof = sof;
      r.pix = m_pix; r.line = m_line; r.lock = m_lock; r.err = rej;
      exp_q.push_back(r);
   endtask

   task automatic drive_now(input logic [DW-1:0] w);
      bus.data_i = w;
      model_step(w);
   endtask

   task automatic put(input logic [DW-1:0] w);
      @(posedge clk);
      #1;
      drive_now(w);
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [7:0] b;
      logic [1:0] lo;
      b  = 8'($urandom_range(1, 254));
      lo = 2'($urandom_range(0, 3));
      return {b, lo};
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) put(rand_word());
   endtask

   task automatic hdr(input logic [7:0] xy);
      put({8'hFF, 2'b11});
      put('0);
      put('0);
      put({xy, 2'b00});
   endtask

   task automatic line(input int n, input logic [7:0] sav, input logic [7:0] eav);
      hdr(sav);
      idle(n);
      hdr(eav);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      model_reset();
      drive_now(rand_word());
   endtask

   function automatic int outs_nonzero();
      return int'(|{bus.data_o, bus.href_o, bus.vsync_o, bus.field_o, bus.sof_o,
                    bus.pix_cnt_o, bus.line_cnt_o, bus.lock_o, bus.hdr_err_o});
   endfunction

   // monitor: one expected record per post-reset cycle
   initial begin
      rec_t r, g;
      forever begin
         @(negedge clk);
         if (rstn && exp_q.size() > 0) begin
            r = exp_q.pop_front();
            g.data = bus.data_o; g.href = bus.href_o; g.vsync = bus.vsync_o;
            g.field = bus.field_o; g.sof = bus.sof_o; g.pix = bus.pix_cnt_o;
            g.line = bus.line_cnt_o; g.lock = bus.lock_o; g.err = bus.hdr_err_o;
            href_seen += int'(g.href);
            sof_seen  += int'(g.sof);
            vectors++;
            if (g !== r) begin
               errors++;
               $display("FAIL scoreboard @%0t: got data=%h href=%b vs=%b fld=%b sof=%b pix=%0d line=%0d lock=%b err=%b, expected data=%h href=%b vs=%b fld=%b sof=%b pix=%0d line=%0d lock=%b err=%b",
                        $time, g.data, g.href, g.vsync, g.field, g.sof, g.pix, g.line, g.lock, g.err,
                        r.data, r.href, r.vsync, r.field, r.sof, r.pix, r.line, r.lock, r.err);
            end
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs, ss;
      logic [7:0] xy;
      bus.data_i = '0;
      #2;
      chk("reset_outputs_zero", outs_nonzero(), 0);
      release_reset();
      idle(19);

      // full 720-word active line
      hs = href_seen;
      line(720, 8'h80, 8'h9D);
      idle(6);
      chk("href_count_720", href_seen - hs, 720);
      #2;
      chk("pix_hold_719", int'(bus.pix_cnt_o), 719);
      chk("lock_after_two_hdrs", int'(bus.lock_o), 1);

      // vertical blanking then first active line of a field
      hdr(8'hB6); idle(10);
      hdr(8'hAB); idle(10);
      hdr(8'hB6); idle(5);
      ss = sof_seen;
      for (int i = 0; i < 3; i++) begin
         line($urandom_range(16, 48), 8'h80, 8'h9D);
         idle($urandom_range(2, 10));
      end
      #2;
      chk("sof_single_pulse", sof_seen - ss, 1);
      chk("line_cnt_after_3", int'(bus.line_cnt_o), 3);

      // rejected header 0x00
      hdr(8'h00);
      put(rand_word());
      #2;
      chk("xy00_hdr_err", int'(bus.hdr_err_o), 1);
      chk("xy00_lock", int'(bus.lock_o), 0);
      chk("xy00_vsync", int'(bus.vsync_o), 0);
      chk("xy00_field", int'(bus.field_o), 0);

      // 0x81: protection error, accepted only without the check
      hdr(8'h81);
      put(rand_word());
      #2;
      chk("xy81_hdr_err", int'(bus.hdr_err_o), PROT ? 1 : 0);
      idle(8);
      hdr(8'h9D);
      idle(6);

      // randomized header/line mix
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 9))
            0: begin xy = 8'($urandom_range(0, 127)); hdr(xy); end
            1: begin xy = 8'($urandom_range(128, 255)); hdr(xy); end
            2: begin
               put({8'hFF, 2'b11}); put('0);
               hdr(mk_xy(1'b0, 1'b0, 1'b1));
            end
            3: begin
               put({8'hFF, 2'b11}); put('0); put('0);
               hdr(mk_xy(1'b0, 1'b1, 1'b1));
            end
            default: begin
               logic f, v;
               f = 1'($urandom_range(0, 1));
               v = 1'($urandom_range(0, 1));
               line($urandom_range(4, 40), mk_xy(f, v, 1'b0), mk_xy(f, v, 1'b1));
            end
         endcase
         idle($urandom_range(0, 8));
      end

      // lock timeout
      line(8, 8'h80, 8'h9D);
      put(rand_word());
      #2;
      chk("lock_before_timeout", int'(bus.lock_o), 1);
      idle(TIMEOUT + 8);
      #2;
      chk("lock_after_timeout", int'(bus.lock_o), 0);

      // reset in the middle of an active line
      hdr(8'h80);
      idle(10);
      #2;
      rstn = 1'b0;
      exp_q.delete();
      #1;
      chk("midline_reset_zero", outs_nonzero(), 0);
      repeat (3) @(posedge clk);
      release_reset();
      hs = href_seen;
      idle(20);
      hdr(8'h9D);
      idle(6);
      chk("no_href_after_reset", href_seen - hs, 0);
      hs = href_seen;
      line(12, 8'h80, 8'h9D);
      idle(6);
      chk("href_next_sav", href_seen - hs, 12);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/bt656_sync_decoder.md
BT656_SYNC_DECODER -- requirements
Module: bt656_sync_decoder

Interface
REQ-001 SHALL have parameter DW, default 10, meaning input/output data width, legal 8 or 10.
REQ-002 SHALL have parameter PIX_CW, default 12, meaning pixel counter width.
REQ-003 SHALL have parameter LINE_CW, default 11, meaning line counter width.
REQ-004 SHALL have parameter TIMEOUT, default 4096, meaning words without a valid header before lock is lost.
REQ-005 SHALL have one clock and one reset: clk_i, input, 1, sole clock (pixel clock); rstn_i, input, 1, asynchronous active-low reset.
REQ-006 SHALL have data_i, input, DW, raw BT.656 word stream, one word per clk_i.
REQ-007 SHALL have data_o, output, DW, data_i delayed 4 cycles.
REQ-008 SHALL have href_o, output, 1, data_o is an active-video word.
REQ-009 SHALL have vsync_o, output, 1, V bit of last accepted header.
REQ-010 SHALL have field_o, output, 1, F bit of last accepted header.
REQ-011 SHALL have sof_o, output, 1, one-cycle start-of-field pulse.
REQ-012 SHALL have pix_cnt_o, output, PIX_CW, index of current href word within the line.
REQ-013 SHALL have line_cnt_o, output, LINE_CW, active line index within the field.
REQ-014 SHALL have lock_o, output, 1, decoder synchronised.
REQ-015 SHALL have hdr_err_o, output, 1, one-cycle pulse on rejected header.

Function
REQ-016 SHALL compare only the upper 8 bits data_i[DW-1 -: 8]; preamble is 0xFF, 0x00, 0x00, then header word XY.
REQ-017 SHALL use FSM states SEARCH, GOT_FF, GOT_00A, GOT_00B: 0xFF from any state -> GOT_FF; GOT_FF + 0x00 -> GOT_00A; GOT_00A + 0x00 -> GOT_00B; GOT_00B decodes XY and -> SEARCH; any other word -> SEARCH.
REQ-018 SHALL accept XY only if bit7 = 1; otherwise pulse hdr_err_o and discard.
REQ-019 SHALL, on an accepted header, update vsync_o and field_o on the following cycle from bits 5 and 6.
REQ-020 SHALL treat an accepted header with H = 0 as SAV and set the internal active flag when V = 0; with H = 1 as EAV and clear it.
REQ-021 SHALL tag each incoming word with the active flag in a 4-stage pipeline with data; on an accepted EAV it SHALL clear the tags of the three preceding preamble words, so href_o never covers header words.
REQ-022 SHALL drive href_o as the stage-4 tag; latency data_i -> data_o/href_o is exactly 4 cycles.
REQ-023 SHALL reset pix_cnt_o to 0 at the first href_o word of a line, increment it per href_o word, and saturate at all-ones.
REQ-024 SHALL pulse sof_o and reset line_cnt_o to 0 when accepted V goes 1 -> 0 or F changes; it SHALL increment line_cnt_o at each EAV ending an active line, saturating.
REQ-025 SHALL set lock_o after two consecutive accepted headers with no rejection between them.
REQ-026 SHALL clear lock_o when TIMEOUT words pass without an accepted header or on hdr_err_o; outputs other than lock_o continue regardless of lock.
REQ-027 SHALL restart preamble detection on a 0xFF in GOT_00A/GOT_00B and SHALL NOT treat it as data.

Reset
REQ-028 SHALL, while rstn_i = 0, force FSM to SEARCH and every output and pipeline stage to 0, with no clk_i edge needed.
REQ-029 SHALL, after reset release mid-line, keep href_o = 0 until the next accepted SAV.

Configuration
REQ-030 SHALL, with BT656_PROT_CHECK_EN defined, also require P3 = V^H, P2 = F^H, P1 = F^V, P0 = F^V^H (bits 3..0) for acceptance, else reject with hdr_err_o.
REQ-031 SHALL, without BT656_PROT_CHECK_EN, ignore bits 3..0.

Structure
REQ-032 SHALL take header bit positions (HDR_BIT_1, FIELD, VBLANK, HBLANK, P3..P0), preamble constants and the FSM state enum from shared package bt656_pkg.
REQ-033 SHALL place preamble/header detection in sub-module bt656_hdr_detect; counters, pipeline and lock live in the top.

Verification
REQ-034 SHALL cover: DW=10, SAV 3FF,000,000,200 + 720 words + EAV 3FF,000,000,274 -> 720 href_o cycles, pix_cnt_o 0..719, first href 4 cycles after first data word.
REQ-035 SHALL cover: header sequence V=1 then SAV XY=0x80 -> sof_o one pulse, line_cnt_o = 0; after 3 active lines line_cnt_o = 3.
REQ-036 SHALL cover: XY = 0x00 after preamble -> hdr_err_o pulse, vsync_o/field_o unchanged, lock_o = 0.
REQ-037 SHALL cover: with BT656_PROT_CHECK_EN, XY = 0x81 -> rejected; without it -> accepted as SAV.
REQ-038 SHALL cover: no header for 4096 words -> lock_o falls; rstn_i low mid-line -> all outputs 0 immediately, href_o = 0 until next SAV.
